// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    // Decoder operation class, as carried on the ID-stage hazard descriptor.
    typedef enum logic [1:0] {
        OpNone  = 2'b00,
        OpAlu   = 2'b01,
        OpLoad  = 2'b10,
        OpStore = 2'b11
    } optype_e;

    // Forwarding mux selects driven back into the EX-stage operand muxes.
    localparam logic [1:0] FWD_RF      = 2'd0;
    localparam logic [1:0] FWD_EX_ALU  = 2'd1;
    localparam logic [1:0] FWD_MEM_ALU = 2'd2;
    localparam logic [1:0] FWD_MEM_LD  = 2'd3;

    // What the controller remembers about each in-flight instruction.
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        optype_e    optype;
        logic [4:0] rs2;
    } stage_rec_t;

    localparam stage_rec_t REC_INVALID = '{
        valid:  1'b0,
        rd:     5'd0,
        optype: OpNone,
        rs2:    5'd0
    };

    // A record produces a register value only for ALU/LOAD ops to a non-zero rd.
    function automatic logic rec_writes(stage_rec_t rec);
        return rec.valid && (rec.optype == OpAlu || rec.optype == OpLoad) && (rec.rd != 5'd0);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// ID-stage hazard descriptor plus the stall/flush/forward controls returned to the datapath.
interface hazard_ctrl_if;

    logic       hold;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic [4:0] id_rd;
    logic       id_rs1use;
    logic       id_rs2use;
    logic [1:0] id_optype;
    logic       id_branch_taken;

    logic [1:0] forward_a;
    logic [1:0] forward_b;
    logic       forward_ls;
    logic       stall_pc;
    logic       stall_fd;
    logic       bubble_de;
    logic       flush_fd;

    // Decoder/datapath side.
    modport master (
        output hold, id_valid, id_rs1, id_rs2, id_rd, id_rs1use, id_rs2use, id_optype,
               id_branch_taken,
        input  forward_a, forward_b, forward_ls, stall_pc, stall_fd, bubble_de, flush_fd
    );

    // Hazard controller side.
    modport slave (
        input  hold, id_valid, id_rs1, id_rs2, id_rd, id_rs1use, id_rs2use, id_optype,
               id_branch_taken,
        output forward_a, forward_b, forward_ls, stall_pc, stall_fd, bubble_de, flush_fd
    );

endinterface

// File: rtl/hazard_stage_reg.sv
// One pipeline-stage record register: loads when enabled, optionally as an empty slot.
module hazard_stage_reg
    import hazard_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       clr,
    input  stage_rec_t d,
    output stage_rec_t q
);

    // Record state; clr takes effect only on an enabled (advancing) cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= REC_INVALID;
        end else if (en) begin
            q <= clr ? REC_INVALID : d;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: tracks EX/MEM/WB destinations and drives forwarding selects,
// load-use stalls, ID/EX bubbles and IF/ID flushes for the 5-stage core.
module hazard_ctrl
    import hazard_pkg::*;
(
    input logic          clk,
    input logic          rst_n,
    hazard_ctrl_if.slave hz
);

    stage_rec_t id_rec;
    stage_rec_t ex_q;
    stage_rec_t mem_q;
    stage_rec_t wb_q;

    logic       advance;
    logic       ex_clr;
    logic       ex_ld_a;
    logic       ex_ld_b;
    logic       load_use;
    logic       flush;
    logic       st_fwd;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;

    // WB store-data index has no consumer; only WB rd/optype matter for forward_ls.
    logic unused_wb_rs2;
    assign unused_wb_rs2 = ^wb_q.rs2;

    function automatic logic src_hit(logic used, logic [4:0] rs, stage_rec_t rec);
        return used && (rs != 5'd0) && (rs == rec.rd) && rec_writes(rec);
    endfunction

    // EX match wins over MEM; an EX load match cannot be forwarded, so select the
    // regfile while the stall holds the instruction in ID.
    function automatic logic [1:0] fwd_sel(logic used, logic [4:0] rs, stage_rec_t ex,
                                           stage_rec_t mem);
        if (src_hit(used, rs, ex)) begin
            return (ex.optype == OpAlu) ? FWD_EX_ALU : FWD_RF;
        end
        if (src_hit(used, rs, mem)) begin
            return (mem.optype == OpAlu) ? FWD_MEM_ALU : FWD_MEM_LD;
        end
        return FWD_RF;
    endfunction

    // Pack the ID descriptor into the record that will enter EX.
    always_comb begin
        id_rec        = REC_INVALID;
        id_rec.valid  = hz.id_valid;
        id_rec.rd     = hz.id_rd;
        id_rec.optype = optype_e'(hz.id_optype);
        id_rec.rs2    = hz.id_rs2;
    end

    assign advance = ~hz.hold;
    // An empty ID slot or a load-use stall both enter EX as a bubble.
    assign ex_clr  = load_use | ~hz.id_valid;

    hazard_stage_reg u_ex_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (advance),
        .clr   (ex_clr),
        .d     (id_rec),
        .q     (ex_q)
    );

    hazard_stage_reg u_mem_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (advance),
        .clr   (1'b0),
        .d     (ex_q),
        .q     (mem_q)
    );

    hazard_stage_reg u_wb_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (advance),
        .clr   (1'b0),
        .d     (mem_q),
        .q     (wb_q)
    );

    // Match, priority and stall/flush decisions from ID inputs and the held records.
    always_comb begin
        ex_ld_a  = 1'b0;
        ex_ld_b  = 1'b0;
        load_use = 1'b0;
        flush    = 1'b0;
        fwd_a    = FWD_RF;
        fwd_b    = FWD_RF;
        st_fwd   = 1'b0;

        ex_ld_a = src_hit(hz.id_rs1use, hz.id_rs1, ex_q) && (ex_q.optype == OpLoad);
        ex_ld_b = src_hit(hz.id_rs2use, hz.id_rs2, ex_q) && (ex_q.optype == OpLoad);

        if (hz.id_valid) begin
            // A store only needs rs2 in MEM, where WB load data can still be forwarded.
            load_use = ex_ld_a || (ex_ld_b && (id_rec.optype != OpStore));
            fwd_a    = fwd_sel(hz.id_rs1use, hz.id_rs1, ex_q, mem_q);
            fwd_b    = fwd_sel(hz.id_rs2use, hz.id_rs2, ex_q, mem_q);
            // Branch outcome is untrustworthy while operands are stale; retry next cycle.
            flush    = hz.id_branch_taken && !load_use;
        end

        // MEM-stage store data path, independent of what currently sits in ID.
        st_fwd = mem_q.valid && (mem_q.optype == OpStore) && wb_q.valid &&
                 (wb_q.optype == OpLoad) && (wb_q.rd != 5'd0) && (mem_q.rs2 == wb_q.rd);
    end

    // Outputs are forced quiet while reset is asserted.
    assign hz.forward_a  = rst_n ? fwd_a : FWD_RF;
    assign hz.forward_b  = rst_n ? fwd_b : FWD_RF;
    assign hz.forward_ls = rst_n & st_fwd;
    assign hz.stall_pc   = rst_n & load_use;
    assign hz.stall_fd   = rst_n & load_use;
    assign hz.bubble_de  = rst_n & load_use;
    assign hz.flush_fd   = rst_n & flush;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed table, multi-cycle sequences, random vs model.
module tb_hazard_ctrl;

    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_ALU   = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_STORE = 2'b11;

    typedef struct {
        logic       valid;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [1:0] op;
        logic       taken;
    } instr_t;

    typedef struct {
        logic [1:0] fa;
        logic [1:0] fb;
        logic       stall;
        logic       flush;
        logic       ls;
    } exp_t;

    typedef struct {
        instr_t mem_i;
        instr_t ex_i;
        instr_t id_i;
        exp_t   exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_ctrl_if hz();

    hazard_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    int n_tests = 0;
    int n_fail = 0;

    function automatic instr_t mk(logic v, logic [4:0] rd, logic [4:0] rs1, logic u1,
                                  logic [4:0] rs2, logic u2, logic [1:0] op, logic tk);
        instr_t i;
        i.valid = v; i.rd = rd; i.rs1 = rs1; i.u1 = u1;
        i.rs2 = rs2; i.u2 = u2; i.op = op; i.taken = tk;
        return i;
    endfunction

    function automatic exp_t mke(logic [1:0] fa, logic [1:0] fb, logic st, logic fl, logic ls);
        exp_t e;
        e.fa = fa; e.fb = fb; e.stall = st; e.flush = fl; e.ls = ls;
        return e;
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input exp_t e, input logic check_ls);
        chk({tag, " forward_a"}, {2'b00, hz.forward_a}, {2'b00, e.fa});
        chk({tag, " forward_b"}, {2'b00, hz.forward_b}, {2'b00, e.fb});
        chk({tag, " stall_pc"}, {3'b000, hz.stall_pc}, {3'b000, e.stall});
        chk({tag, " stall_fd"}, {3'b000, hz.stall_fd}, {3'b000, e.stall});
        chk({tag, " bubble_de"}, {3'b000, hz.bubble_de}, {3'b000, e.stall});
        chk({tag, " flush_fd"}, {3'b000, hz.flush_fd}, {3'b000, e.flush});
        if (check_ls) chk({tag, " forward_ls"}, {3'b000, hz.forward_ls}, {3'b000, e.ls});
    endtask

    task automatic drive(input instr_t i);
        hz.id_valid        = i.valid;
        hz.id_rd           = i.rd;
        hz.id_rs1          = i.rs1;
        hz.id_rs1use       = i.u1;
        hz.id_rs2          = i.rs2;
        hz.id_rs2use       = i.u2;
        hz.id_optype       = i.op;
        hz.id_branch_taken = i.taken;
    endtask

    // Called just after a rising edge; leaves the pipeline empty and reset released.
    task automatic pulse_reset();
        rst_n = 1'b0;
        hz.hold = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, OP_NONE, 0));
        #1;
        rst_n = 1'b1;
    endtask

    // Reference model: pipe[0] is the youngest in-flight instruction (EX), pipe[2] the oldest.
    function automatic logic produces(instr_t p);
        return p.valid && (p.op == OP_ALU || p.op == OP_LOAD) && (p.rd != 0);
    endfunction

    function automatic exp_t model(instr_t id, instr_t p0, instr_t p1, instr_t p2);
        exp_t e;
        logic [1:0] sel [2];
        logic       ld_hit [2];
        logic [4:0] rs [2];
        logic       used [2];
        rs[0] = id.rs1; used[0] = id.u1;
        rs[1] = id.rs2; used[1] = id.u2;
        for (int s = 0; s < 2; s++) begin
            sel[s] = 2'd0;
            ld_hit[s] = 1'b0;
            if (used[s] && rs[s] != 0) begin
                // Nearest older producer of the register decides.
                if (produces(p0) && p0.rd == rs[s]) begin
                    if (p0.op == OP_ALU) sel[s] = 2'd1;
                    else ld_hit[s] = 1'b1;
                end else if (produces(p1) && p1.rd == rs[s]) begin
                    sel[s] = (p1.op == OP_ALU) ? 2'd2 : 2'd3;
                end
            end
        end
        e.stall = id.valid && (ld_hit[0] || (ld_hit[1] && id.op != OP_STORE));
        e.fa    = id.valid ? sel[0] : 2'd0;
        e.fb    = id.valid ? sel[1] : 2'd0;
        e.flush = id.valid && id.taken && !e.stall;
        e.ls    = p1.valid && p1.op == OP_STORE && p2.valid && p2.op == OP_LOAD &&
                  p2.rd != 0 && p1.rs2 == p2.rd;
        return e;
    endfunction

    vec_t   vecs [13];
    instr_t nop;
    instr_t none_i;
    instr_t lw5;
    instr_t pipe [3];
    instr_t cur;
    exp_t   e;
    logic   cur_hold;

    initial begin
        nop    = mk(1, 0, 0, 0, 0, 0, OP_NONE, 0);
        none_i = mk(0, 0, 0, 0, 0, 0, OP_NONE, 0);
        lw5    = mk(1, 5, 8, 0, 0, 0, OP_LOAD, 0);

        // {MEM instr, EX instr, ID instr, expected}; fed instrs use no sources.
        vecs[0]  = '{none_i, mk(1, 5, 0, 0, 0, 0, OP_ALU, 0),
                     mk(1, 6, 5, 1, 7, 1, OP_ALU, 0), mke(1, 0, 0, 0, 0)};
        vecs[1]  = '{none_i, lw5, mk(1, 6, 5, 1, 5, 1, OP_ALU, 0), mke(0, 0, 1, 0, 0)};
        vecs[2]  = '{none_i, lw5, mk(1, 0, 8, 1, 5, 1, OP_STORE, 0), mke(0, 0, 0, 0, 0)};
        vecs[3]  = '{lw5, mk(1, 5, 0, 0, 0, 0, OP_ALU, 0),
                     mk(1, 6, 5, 1, 0, 0, OP_ALU, 0), mke(1, 0, 0, 0, 0)};
        vecs[4]  = '{none_i, mk(1, 0, 0, 0, 0, 0, OP_ALU, 0),
                     mk(1, 6, 0, 1, 0, 1, OP_ALU, 0), mke(0, 0, 0, 0, 0)};
        vecs[5]  = '{none_i, none_i, mk(1, 0, 1, 1, 2, 1, OP_NONE, 1), mke(0, 0, 0, 1, 0)};
        vecs[6]  = '{none_i, mk(1, 1, 0, 0, 0, 0, OP_LOAD, 0),
                     mk(1, 0, 1, 1, 2, 1, OP_NONE, 1), mke(0, 0, 1, 0, 0)};
        vecs[7]  = '{mk(1, 9, 0, 0, 0, 0, OP_ALU, 0), nop,
                     mk(1, 4, 3, 1, 9, 1, OP_ALU, 0), mke(0, 2, 0, 0, 0)};
        vecs[8]  = '{mk(1, 9, 0, 0, 0, 0, OP_LOAD, 0), nop,
                     mk(1, 4, 9, 1, 3, 1, OP_ALU, 0), mke(3, 0, 0, 0, 0)};
        vecs[9]  = '{none_i, mk(1, 3, 0, 0, 0, 0, OP_ALU, 0),
                     mk(1, 4, 3, 1, 3, 0, OP_ALU, 0), mke(1, 0, 0, 0, 0)};
        vecs[10] = '{none_i, mk(1, 3, 0, 0, 0, 0, OP_ALU, 0),
                     mk(0, 4, 3, 1, 3, 1, OP_ALU, 1), mke(0, 0, 0, 0, 0)};
        vecs[11] = '{none_i, mk(1, 5, 0, 0, 0, 0, OP_STORE, 0),
                     mk(1, 6, 5, 1, 5, 1, OP_ALU, 0), mke(0, 0, 0, 0, 0)};
        vecs[12] = '{none_i, lw5, mk(1, 0, 5, 1, 8, 1, OP_STORE, 0), mke(0, 0, 1, 0, 0)};

        hz.hold = 1'b0;
        drive(none_i);
        #3;
        check_all("reset", mke(0, 0, 0, 0, 0), 1'b1);
        rst_n = 1'b1;

        for (int k = 0; k < 13; k++) begin
            @(posedge clk); #1;
            pulse_reset();
            drive(vecs[k].mem_i);
            @(posedge clk); #1;
            drive(vecs[k].ex_i);
            @(posedge clk); #1;
            drive(vecs[k].id_i);
            @(negedge clk);
            check_all($sformatf("vec%0d", k), vecs[k].exp, 1'b1);
        end

        // Load-use: one stall cycle, then both operands from MEM load data.
        @(posedge clk); #1;
        pulse_reset();
        drive(lw5);
        @(posedge clk); #1;
        drive(mk(1, 6, 5, 1, 5, 1, OP_ALU, 0));
        @(negedge clk);
        check_all("lu_stall", mke(0, 0, 1, 0, 0), 1'b1);
        @(posedge clk);
        @(negedge clk);
        check_all("lu_fwd", mke(3, 3, 0, 0, 0), 1'b1);

        // Store data from a just-loaded register, resolved two cycles later.
        @(posedge clk); #1;
        pulse_reset();
        drive(lw5);
        @(posedge clk); #1;
        drive(mk(1, 0, 8, 1, 5, 1, OP_STORE, 0));
        @(negedge clk);
        check_all("st_nostall", mke(0, 0, 0, 0, 0), 1'b1);
        @(posedge clk); #1;
        drive(nop);
        @(negedge clk);
        check_all("st_ls0", mke(0, 0, 0, 0, 0), 1'b1);
        @(posedge clk);
        @(negedge clk);
        check_all("st_ls1", mke(0, 0, 0, 0, 1), 1'b1);

        // Load-use held by hold for three cycles, then reset mid-stall.
        @(posedge clk); #1;
        pulse_reset();
        drive(lw5);
        @(posedge clk); #1;
        drive(mk(1, 6, 5, 1, 5, 1, OP_ALU, 0));
        hz.hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_all($sformatf("hold%0d", c), mke(0, 0, 1, 0, 0), 1'b1);
            @(posedge clk);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_all("rst_mid", mke(0, 0, 0, 0, 0), 1'b1);
        hz.hold = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(mk(1, 6, 5, 1, 5, 1, OP_ALU, 0));
        @(negedge clk);
        check_all("post_rst", mke(0, 0, 0, 0, 0), 1'b1);

        // Random traffic against the reference model.
        @(posedge clk); #1;
        pulse_reset();
        for (int p = 0; p < 3; p++) pipe[p] = none_i;
        for (int c = 0; c < 500; c++) begin
            cur = mk($urandom_range(0, 7) != 0, 5'($urandom_range(0, 3)),
                     5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     2'($urandom_range(0, 3)), $urandom_range(0, 3) == 0);
            cur_hold = ($urandom_range(0, 7) == 0);
            drive(cur);
            hz.hold = cur_hold;
            @(negedge clk);
            e = model(cur, pipe[0], pipe[1], pipe[2]);
            // forward_ls belongs to the MEM stage; only scored while ID is occupied.
            check_all($sformatf("rnd%0d", c), e, cur.valid);
            @(posedge clk);
            if (!cur_hold) begin
                pipe[2] = pipe[1];
                pipe[1] = pipe[0];
                pipe[0] = (cur.valid && !e.stall) ? cur : none_i;
            end
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
